// File: rtl/mips_avalon_arbiter.sv
// Two-master / one-slave Avalon-MM arbiter with registered grant (m0 = CPU, m1 = loader/DMA).
// Define ARB_ROUND_ROBIN_EN to alternate ties between masters; default is fixed priority to m0.
module mips_avalon_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W-1:0]   m0_writedata,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_writedata,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic [ADDR_W-1:0]   s_address,
  output logic                s_read,
  output logic                s_write,
  output logic [DATA_W-1:0]   s_writedata,
  output logic [DATA_W/8-1:0] s_byteenable,
  input  logic                s_waitrequest,
  input  logic [DATA_W-1:0]   s_readdata,
  output logic [1:0]          grant
);

  typedef struct packed {
    logic [ADDR_W-1:0]   address;
    logic                read;
    logic                write;
    logic [DATA_W-1:0]   writedata;
    logic [DATA_W/8-1:0] byteenable;
  } av_req_t;

  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

  state_t  state, state_nxt;
  av_req_t m0_req, m1_req, s_req;
  logic    req0, req1, pick0;

  assign m0_req = '{m0_address, m0_read, m0_write, m0_writedata, m0_byteenable};
  assign m1_req = '{m1_address, m1_read, m1_write, m1_writedata, m1_byteenable};
  assign req0   = m0_read | m0_write;
  assign req1   = m1_read | m1_write;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_grant;

  // Ownership ends on completion or on an illegal strobe drop; either counts as a turn.
  always_ff @(posedge clk) begin
    if (reset)
      last_grant <= 1'b1;
    else if (state == GRANT0 && (!req0 || !s_waitrequest))
      last_grant <= 1'b0;
    else if (state == GRANT1 && (!req1 || !s_waitrequest))
      last_grant <= 1'b1;
  end

  assign pick0 = last_grant;
`else
  assign pick0 = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req0 && (!req1 || pick0)) state_nxt = GRANT0;
        else if (req1)                state_nxt = GRANT1;
      end
      GRANT0: if (!req0 || !s_waitrequest) state_nxt = IDLE;
      GRANT1: if (!req1 || !s_waitrequest) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Steering is selected by the registered state only, so no arbitration logic sits on m*->s* paths.
  always_comb begin
    s_req          = '0;
    m0_waitrequest = 1'b1;
    m1_waitrequest = 1'b1;
    grant          = 2'b00;
    case (state)
      GRANT0: begin
        s_req          = m0_req;
        m0_waitrequest = s_waitrequest;
        grant          = 2'b01;
      end
      GRANT1: begin
        s_req          = m1_req;
        m1_waitrequest = s_waitrequest;
        grant          = 2'b10;
      end
      default: ;
    endcase
  end

  assign s_address    = s_req.address;
  assign s_read       = s_req.read;
  assign s_write      = s_req.write;
  assign s_writedata  = s_req.writedata;
  assign s_byteenable = s_req.byteenable;

  assign m0_readdata = s_readdata;
  assign m1_readdata = s_readdata;

endmodule

// File: tb/tb_mips_avalon_arbiter.sv
// Scoreboard bench for mips_avalon_arbiter: stimulus pushes expected slave completions,
// a negedge monitor pops and compares them; directed checks cover grant timing and steering.
module tb_mips_avalon_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] m0_address = '0, m1_address = '0, s_address;
  logic        m0_read = 1'b0, m0_write = 1'b0, m1_read = 1'b0, m1_write = 1'b0;
  logic [31:0] m0_writedata = '0, m1_writedata = '0, s_writedata;
  logic [3:0]  m0_byteenable = '0, m1_byteenable = '0, s_byteenable;
  logic        m0_waitrequest, m1_waitrequest, s_read, s_write, s_waitrequest;
  logic [31:0] m0_readdata, m1_readdata, s_readdata;
  logic [1:0]  grant;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]  gnt;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } exp_t;
  exp_t exp_q[$];

  // Slave model: each access stalls for wait_cfg cycles, then completes.
  int          wait_cfg = 0;
  int          wcnt = 0;
  logic [31:0] rdata = 32'h0;
  assign s_waitrequest = (s_read || s_write) && (wcnt != 0);
  assign s_readdata    = rdata;

  always @(posedge clk) begin
    if ((s_read || s_write) && wcnt != 0) wcnt <= wcnt - 1;
    else                                  wcnt <= wait_cfg;
  end

  always #5 clk = ~clk;

  mips_avalon_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
    .s_address(s_address), .s_read(s_read), .s_write(s_write),
    .s_writedata(s_writedata), .s_byteenable(s_byteenable),
    .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
    .grant(grant)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push(input int k, input logic wr, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] be);
    exp_t e;
    e.gnt = (k == 0) ? 2'b01 : 2'b10;
    e.wr = wr; e.addr = a; e.data = d; e.be = be;
    exp_q.push_back(e);
  endtask

  // Avalon master: hold the request until waitrequest is low, then drop it after the edge.
  task automatic xfer(input int k, input logic wr, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] be);
    int n = 0;
    bit done = 1'b0;
    if (k == 0) begin
      m0_address = a; m0_read = !wr; m0_write = wr; m0_writedata = d; m0_byteenable = be;
    end else begin
      m1_address = a; m1_read = !wr; m1_write = wr; m1_writedata = d; m1_byteenable = be;
    end
    while (!done && n < 200) begin
      @(negedge clk);
      done = (k == 0) ? !m0_waitrequest : !m1_waitrequest;
      n++;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL xfer_timeout master %0d addr %h: got no completion, required one", k, a);
    end
    @(posedge clk); #1;
    if (k == 0) begin m0_read = 1'b0; m0_write = 1'b0; end
    else        begin m1_read = 1'b0; m1_write = 1'b0; end
  endtask

  task automatic do_reset();
    m0_read = 1'b0; m0_write = 1'b0; m1_read = 1'b0; m1_write = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Scoreboard monitor: every slave-side completion must match the next expected transfer.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && (s_read || s_write) && !s_waitrequest) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb_unexpected: got completion grant=%b addr=%h, required none", grant, s_address);
      end else begin
        e = exp_q.pop_front();
        chk("sb_grant", 64'(grant), 64'(e.gnt));
        chk("sb_req", 64'({s_write, s_address}), 64'({e.wr, e.addr}));
        chk("sb_be", 64'(s_byteenable), 64'(e.be));
        if (e.wr) chk("sb_wdata", 64'(s_writedata), 64'(e.data));
        else      chk("sb_rdata", 64'((e.gnt == 2'b01) ? m0_readdata : m1_readdata), 64'(e.data));
        chk("sb_wait", 64'({m0_waitrequest, m1_waitrequest}), 64'((e.gnt == 2'b01) ? 2'b01 : 2'b10));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, required finish");
    $fatal(1);
  end

  initial begin
    // Reset and idle: non-strobed master inputs must not leak to the slave.
    m0_address = 32'hFFFF_FFFF; m1_writedata = 32'h1234_5678; m1_byteenable = 4'hF;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_ctrl", 64'({grant, s_read, s_write, m0_waitrequest, m1_waitrequest}), 64'(6'b00_00_11));
      chk("idle_zero", 64'({s_address, s_writedata, s_byteenable}), 64'(0));
    end

    // m0 zero-wait read.
    wait_cfg = 0; rdata = 32'h2402_0005;
    do_reset();
    push(0, 1'b0, 32'hBFC0_0000, 32'h2402_0005, 4'hF);
    fork
      xfer(0, 1'b0, 32'hBFC0_0000, 32'h0, 4'hF);
      begin
        @(negedge clk);
        chk("rd_req_cycle", 64'({grant, m0_waitrequest}), 64'(3'b00_1));
        @(negedge clk);
        chk("rd_grant", 64'({grant, m0_waitrequest, s_read}), 64'(4'b01_0_1));
        chk("rd_data", 64'(m0_readdata), 64'(32'h2402_0005));
        @(negedge clk);
        chk("rd_idle_after", 64'(grant), 64'(2'b00));
      end
    join

    // m1 write stalled 3 cycles while m0 waits its turn.
    wait_cfg = 3; rdata = 32'h0BAD_F00D;
    do_reset();
    push(1, 1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 4'b0011);
    push(0, 1'b0, 32'h0000_0040, 32'h0BAD_F00D, 4'hF);
    fork
      xfer(1, 1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 4'b0011);
      begin @(posedge clk); #1; xfer(0, 1'b0, 32'h0000_0040, 32'h0, 4'hF); end
      begin
        @(posedge clk);
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          chk("wr_steady", 64'({grant, s_write, s_read, m0_waitrequest}), 64'(5'b10_1_0_1));
          chk("wr_fields", {s_address[15:0], s_writedata, s_byteenable, 12'h0},
              {16'h1000, 32'hDEAD_BEEF, 4'b0011, 12'h0});
        end
        @(negedge clk);
        chk("wr_bubble", 64'({grant, m0_waitrequest}), 64'(3'b00_1));
      end
    join

    // Both masters request together, 4 transfers each.
    wait_cfg = 0; rdata = 32'hCAFE_0000;
    do_reset();
`ifdef ARB_ROUND_ROBIN_EN
    for (int i = 0; i < 4; i++) begin
      push(0, 1'b0, 32'h100 + 32'(i * 4), 32'hCAFE_0000, 4'hF);
      push(1, 1'b1, 32'h2000 + 32'(i * 4), 32'hA500_0000 + 32'(i), 4'hF);
    end
`else
    for (int i = 0; i < 4; i++) push(0, 1'b0, 32'h100 + 32'(i * 4), 32'hCAFE_0000, 4'hF);
    for (int i = 0; i < 4; i++) push(1, 1'b1, 32'h2000 + 32'(i * 4), 32'hA500_0000 + 32'(i), 4'hF);
`endif
    fork
      for (int i = 0; i < 4; i++) xfer(0, 1'b0, 32'h100 + 32'(i * 4), 32'h0, 4'hF);
      for (int j = 0; j < 4; j++) xfer(1, 1'b1, 32'h2000 + 32'(j * 4), 32'hA500_0000 + 32'(j), 4'hF);
    join

    // Reset while m1 is granted and stalled.
    wait_cfg = 5;
    do_reset();
    m1_address = 32'h3000; m1_writedata = 32'h7777_8888; m1_byteenable = 4'hF; m1_write = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_pre", 64'({grant, s_write, s_waitrequest}), 64'(4'b10_1_1));
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_drop", 64'({grant, s_write, m1_waitrequest}), 64'(4'b00_0_1));
    m1_write = 1'b0; wait_cfg = 0; rdata = 32'h0000_5A5A;
    @(posedge clk); #1;
    push(0, 1'b0, 32'h0000_0200, 32'h0000_5A5A, 4'hF);
    xfer(0, 1'b0, 32'h0000_0200, 32'h0, 4'hF);

    // m0 abandons a stalled read; pending m1 takes over.
    wait_cfg = 3;
    do_reset();
    push(1, 1'b1, 32'h4000, 32'h55AA_55AA, 4'b1100);
    fork
      xfer(1, 1'b1, 32'h4000, 32'h55AA_55AA, 4'b1100);
      begin
        m0_address = 32'h5000; m0_byteenable = 4'hF; m0_read = 1'b1;
        @(negedge clk);
        chk("ab_req", 64'({grant, m0_waitrequest}), 64'(3'b00_1));
        @(negedge clk);
        chk("ab_stall", 64'({grant, m0_waitrequest, s_read}), 64'(4'b01_1_1));
        @(posedge clk); #1 m0_read = 1'b0;
        @(negedge clk);
        chk("ab_drop", 64'({grant, s_read}), 64'(3'b01_0));
        @(negedge clk);
        chk("ab_idle", 64'(grant), 64'(2'b00));
        @(negedge clk);
        chk("ab_m1", 64'(grant), 64'(2'b10));
      end
    join

    repeat (2) @(negedge clk);
    chk("sb_empty", 64'(exp_q.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
